// File: rtl/instr_mem_pipelined.sv
// Word-addressed instruction store for the fetch stage: valid/ready fetch port, 1- or 2-cycle
// read latency, in-order response queue, runtime program load and redirect flush.
module instr_mem_pipelined #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LATENCY    = 1,
  parameter string       INIT_FILE  = "",
  localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  input  logic                  flush,
  input  logic                  ld_en,
  input  logic [IDX_W-1:0]      ld_idx,
  input  logic [DATA_WIDTH-1:0] ld_data
);

  localparam int unsigned QD    = LATENCY + 1;
  localparam int unsigned PTR_W = $clog2(QD);
  localparam int unsigned CNT_W = $clog2(QD + 1);

  // ---------------------------------------------------------------------------
  // Program store
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i] = '0;
    end
  end

  // Loads are not reset so a downloaded program survives a core reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Request decode and acceptance
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]      idx;
  logic                  hi_err;
  logic                  addr_err;
  logic                  acc;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic [CNT_W-1:0]      outst_q, outst_d;

  assign idx = req_addr[IDX_W+1:2];

  if (ADDR_WIDTH > IDX_W + 2) begin : g_hi_chk
    assign hi_err = |req_addr[ADDR_WIDTH-1:IDX_W+2];
  end else begin : g_no_hi_chk
    assign hi_err = 1'b0;
  end

  assign addr_err   = (req_addr[1:0] != 2'b00) || hi_err;
  assign req_ready  = rst_n && !ld_en && !flush && (outst_q < CNT_W'(QD));
  assign acc        = req_valid && req_ready;
  assign fetch_data = addr_err ? '0 : mem[idx];

  // ---------------------------------------------------------------------------
  // Read pipeline: the array is sampled at the accept edge, then LATENCY-1 stages
  // ---------------------------------------------------------------------------
  logic                  push_v;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push_err;

  if (LATENCY == 1) begin : g_direct
    assign push_v    = acc;
    assign push_data = fetch_data;
    assign push_err  = addr_err;
  end else begin : g_pipe
    localparam int unsigned NSTG = LATENCY - 1;

    logic [NSTG-1:0]       pv_q;
    logic [NSTG-1:0]       pe_q;
    logic [DATA_WIDTH-1:0] pd_q [NSTG];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv_q <= '0;
        pe_q <= '0;
        for (int i = 0; i < int'(NSTG); i++) begin
          pd_q[i] <= '0;
        end
      end else begin
        pv_q[0] <= acc;
        pe_q[0] <= addr_err;
        pd_q[0] <= fetch_data;
        for (int i = 1; i < int'(NSTG); i++) begin
          pv_q[i] <= pv_q[i-1] && !flush;
          pe_q[i] <= pe_q[i-1];
          pd_q[i] <= pd_q[i-1];
        end
      end
    end

    assign push_v    = pv_q[NSTG-1];
    assign push_data = pd_q[NSTG-1];
    assign push_err  = pe_q[NSTG-1];
  end

  // ---------------------------------------------------------------------------
  // In-order response queue
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] qd_q [QD];
  logic [QD-1:0]         qe_q;
  logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  push, pop;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QD - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A flush drops whatever the last pipeline stage delivers on the same edge.
  assign push = push_v && !flush;
  assign pop  = resp_valid_q && resp_ready && !flush;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    outst_d = outst_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      outst_d = '0;
    end else begin
      if (push) wr_d = ptr_inc(wr_q);
      if (pop)  rd_d = ptr_inc(rd_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
      case ({acc, pop})
        2'b10:   outst_d = outst_q + CNT_W'(1);
        2'b01:   outst_d = outst_q - CNT_W'(1);
        default: outst_d = outst_q;
      endcase
    end
  end

  // Next head is precomputed so the response port is driven straight from flops.
  always_comb begin
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    resp_err_d   = 1'b0;
    if (cnt_d != '0) begin
      resp_valid_d = 1'b1;
      if (push && (wr_q == rd_d)) begin
        resp_data_d = push_data;
        resp_err_d  = push_err;
      end else begin
        resp_data_d = qd_q[rd_d];
        resp_err_d  = qe_q[rd_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qd_q[wr_q] <= push_data;
      qe_q[wr_q] <= push_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      outst_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      outst_q      <= outst_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> ((cnt_q < CNT_W'(QD)) || pop));
  a_outst_bound: assert property (@(posedge clk) disable iff (!rst_n)
    outst_q <= CNT_W'(QD));
  a_cnt_le_outst: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= outst_q);

endmodule
